// File: rtl/vco_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// vco_seq_ctrl_if
// Groups the control/configuration inputs and the status/VCO-control outputs
// of the VCO stress/measure sequencer.
//   master : drives start/abort/configuration, observes outputs (testbench/host)
//   slave  : the sequencer itself
// Signals
//   start, abort         run request / run termination
//   stress_cycles        stress-phase length (CNT_W)
//   meas_cycles          measure-window length (CNT_W)
//   num_rounds           stress+measure rounds per run (8)
//   div_sel_cfg          divider select applied while measuring (2)
//   en_vco, clk_kill, load, vco_div_sel   VCO / counter control
//   busy, done, aborted, phase, round_cnt status
// ---------------------------------------------------------------------------
interface vco_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] stress_cycles;
    logic [CNT_W-1:0] meas_cycles;
    logic [7:0]       num_rounds;
    logic [1:0]       div_sel_cfg;

    logic             en_vco;
    logic             clk_kill;
    logic             load;
    logic [1:0]       vco_div_sel;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       phase;
    logic [7:0]       round_cnt;

    modport master (
        output start, abort, stress_cycles, meas_cycles, num_rounds, div_sel_cfg,
        input  en_vco, clk_kill, load, vco_div_sel, busy, done, aborted, phase, round_cnt
    );

    modport slave (
        input  start, abort, stress_cycles, meas_cycles, num_rounds, div_sel_cfg,
        output en_vco, clk_kill, load, vco_div_sel, busy, done, aborted, phase, round_cnt
    );
endinterface

// File: rtl/vco_seq_ctrl.sv
// ---------------------------------------------------------------------------
// vco_seq_ctrl
// Sequences repeated stress/settle/measure/gap rounds around a VCO.
// Ports
//   clk    sole clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    vco_seq_ctrl_if.slave (configuration in, VCO control/status out)
// Configuration is captured into shadow registers when a run starts, so the
// configuration inputs may change freely during a run. Every output is a
// register loaded from the next-state decode, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module vco_seq_ctrl #(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    vco_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STRESS = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // state and phase counter
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       round_cnt_r;

    // configuration captured at start
    logic [CNT_W-1:0] sh_stress_r;
    logic [CNT_W-1:0] sh_meas_r;
    logic [7:0]       sh_rounds_r;
    logic [1:0]       sh_div_r;

    // registered outputs
    logic             en_vco_r;
    logic             clk_kill_r;
    logic             load_r;
    logic [1:0]       div_r;
    logic             busy_r;
    logic             done_r;
    logic             aborted_r;
    logic [2:0]       phase_r;

    // next-state signals
    logic             start_ok_s;
    logic [CNT_W-1:0] eff_stress_s;
    logic [1:0]       eff_div_s;
    logic [CNT_W-1:0] meas_load_s;
    logic [7:0]       round_inc_s;
    state_t           entry_state_s;
    logic [CNT_W-1:0] entry_cnt_s;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]       round_nxt_s;
    logic             done_nxt_s;
    logic             aborted_nxt_s;
    logic             en_vco_nxt_s;
    logic             clk_kill_nxt_s;
    logic             load_nxt_s;
    logic [1:0]       div_nxt_s;

    // ABORT beats START in IDLE, so a simultaneous pair does nothing.
    assign start_ok_s  = (state_r == ST_IDLE) && bus.start && !bus.abort;

    // On the start cycle the shadows are not loaded yet, so use the inputs.
    assign eff_stress_s = start_ok_s ? bus.stress_cycles : sh_stress_r;
    assign eff_div_s    = start_ok_s ? bus.div_sel_cfg   : sh_div_r;

    // A zero measure length still yields one measure cycle.
    assign meas_load_s = (sh_meas_r == CNT_ZERO) ? CNT_ZERO : (sh_meas_r - CNT_ONE);
    assign round_inc_s = round_cnt_r + 8'd1;

    // Entry point of a round: STRESS, or straight to SETTLE when the stress length is zero
    always_comb begin
        entry_state_s = ST_STRESS;
        entry_cnt_s   = CNT_ZERO;
        if (eff_stress_s != CNT_ZERO) begin
            entry_state_s = ST_STRESS;
            entry_cnt_s   = eff_stress_s - CNT_ONE;
        end else begin
            entry_state_s = ST_SETTLE;
            entry_cnt_s   = SETTLE_LOAD;
        end
    end

    // Next state, phase counter, round count and completion pulses
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        round_nxt_s   = round_cnt_r;
        done_nxt_s    = 1'b0;
        aborted_nxt_s = 1'b0;
        // Counters hold (phase length - 1) and leave the phase at zero, so
        // they never wrap and an all-ones length gives all-ones cycles.
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    round_nxt_s = 8'd0;
                    if (bus.num_rounds == 8'd0) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = entry_state_s;
                        cnt_nxt_s   = entry_cnt_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STRESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = SETTLE_LOAD;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_MEAS;
                    cnt_nxt_s   = meas_load_s;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_MEAS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                round_nxt_s = round_inc_s;
                if (round_inc_s == sh_rounds_r) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = entry_state_s;
                    cnt_nxt_s   = entry_cnt_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        // Abort overrides everything in a run and freezes the round count.
        if ((state_r != ST_IDLE) && bus.abort) begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            round_nxt_s   = round_cnt_r;
            done_nxt_s    = 1'b0;
            aborted_nxt_s = 1'b1;
        end else begin
            aborted_nxt_s = aborted_nxt_s;
        end
    end

    // Output decode of the next state; GAP keeps the measurement divider selected
    always_comb begin
        en_vco_nxt_s   = 1'b0;
        clk_kill_nxt_s = 1'b0;
        load_nxt_s     = 1'b0;
        div_nxt_s      = 2'b11;
        case (state_nxt_s)
            ST_IDLE: begin
                en_vco_nxt_s = 1'b0;
            end
            ST_STRESS: begin
                en_vco_nxt_s = 1'b1;
            end
            ST_SETTLE: begin
                en_vco_nxt_s   = 1'b1;
                clk_kill_nxt_s = 1'b1;
                div_nxt_s      = eff_div_s;
            end
            ST_MEAS: begin
                en_vco_nxt_s   = 1'b1;
                clk_kill_nxt_s = 1'b1;
                load_nxt_s     = 1'b1;
                div_nxt_s      = eff_div_s;
            end
            ST_GAP: begin
                en_vco_nxt_s   = 1'b1;
                clk_kill_nxt_s = 1'b1;
                div_nxt_s      = eff_div_s;
            end
            default: begin
                en_vco_nxt_s = 1'b0;
            end
        endcase
    end

    // Sequencer registers, shadow capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            round_cnt_r <= 8'd0;
            sh_stress_r <= CNT_ZERO;
            sh_meas_r   <= CNT_ZERO;
            sh_rounds_r <= 8'd0;
            sh_div_r    <= 2'b00;
            en_vco_r    <= 1'b0;
            clk_kill_r  <= 1'b0;
            load_r      <= 1'b0;
            div_r       <= 2'b11;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            phase_r     <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            round_cnt_r <= round_nxt_s;
            if (start_ok_s) begin
                sh_stress_r <= bus.stress_cycles;
                sh_meas_r   <= bus.meas_cycles;
                sh_rounds_r <= bus.num_rounds;
                sh_div_r    <= bus.div_sel_cfg;
            end
            en_vco_r    <= en_vco_nxt_s;
            clk_kill_r  <= clk_kill_nxt_s;
            load_r      <= load_nxt_s;
            div_r       <= div_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= done_nxt_s;
            aborted_r   <= aborted_nxt_s;
            phase_r     <= state_nxt_s;
        end
    end

    assign bus.en_vco      = en_vco_r;
    assign bus.clk_kill    = clk_kill_r;
    assign bus.load        = load_r;
    assign bus.vco_div_sel = div_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.aborted     = aborted_r;
    assign bus.phase       = phase_r;
    assign bus.round_cnt   = round_cnt_r;

endmodule

// File: tb/tb_vco_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vco_seq_ctrl
// Directed scenarios plus randomized traffic for vco_seq_ctrl. A timeline
// model expands each accepted run into a queue of per-cycle phases and is
// compared against the DUT after every clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vco_seq_ctrl;
    localparam int CNT_W    = 8;
    localparam int SETTLE   = 4;
    localparam int P_IDLE   = 0;
    localparam int P_STRESS = 1;
    localparam int P_SETTLE = 2;
    localparam int P_MEAS   = 3;
    localparam int P_GAP    = 4;

    logic clk = 1'b0;
    logic reset;

    vco_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    vco_seq_ctrl #(.CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model + per-cycle compare ----------------
    int tl[$];
    int m_phase = 0;
    int m_rc    = 0;
    int m_div   = 0;
    int m_done  = 0;
    int m_ab    = 0;
    bit m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            m_done = 0;
            m_ab   = 0;
            if (reset) begin
                tl.delete();
                m_phase = P_IDLE;
                m_rc    = 0;
                m_valid = 1'b1;
            end else if (m_phase != P_IDLE) begin
                if (bus.abort) begin
                    tl.delete();
                    m_phase = P_IDLE;
                    m_ab    = 1;
                end else begin
                    if (m_phase == P_GAP) m_rc++;
                    if (tl.size() == 0) begin
                        m_phase = P_IDLE;
                        m_done  = 1;
                    end else begin
                        m_phase = tl.pop_front();
                    end
                end
            end else if (bus.start && !bus.abort) begin
                m_rc = 0;
                if (bus.num_rounds == 8'd0) begin
                    m_done = 1;
                end else begin
                    m_div = int'(bus.div_sel_cfg);
                    for (int r = 0; r < int'(bus.num_rounds); r++) begin
                        repeat (int'(bus.stress_cycles)) tl.push_back(P_STRESS);
                        repeat (SETTLE) tl.push_back(P_SETTLE);
                        repeat ((bus.meas_cycles == 8'd0) ? 1 : int'(bus.meas_cycles)) tl.push_back(P_MEAS);
                        tl.push_back(P_GAP);
                    end
                    m_phase = tl.pop_front();
                end
            end
            #1;
            if (m_valid) begin
                chk("phase",     bus.phase,       m_phase);
                chk("busy",      bus.busy,        (m_phase != P_IDLE) ? 1 : 0);
                chk("en_vco",    bus.en_vco,      (m_phase != P_IDLE) ? 1 : 0);
                chk("clk_kill",  bus.clk_kill,    (m_phase >= P_SETTLE) ? 1 : 0);
                chk("load",      bus.load,        (m_phase == P_MEAS) ? 1 : 0);
                chk("div_sel",   bus.vco_div_sel, (m_phase >= P_SETTLE) ? m_div : 3);
                chk("done",      bus.done,        m_done);
                chk("aborted",   bus.aborted,     m_ab);
                chk("round_cnt", bus.round_cnt,   m_rc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input int s, input int m, input int r, input int d);
        bus.stress_cycles = CNT_W'(s);
        bus.meas_cycles   = CNT_W'(m);
        bus.num_rounds    = 8'(r);
        bus.div_sel_cfg   = 2'(d);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 of the first cycle after acceptance.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    int o_stress, o_settle, o_meas, o_gap, o_load, o_done, o_ab, o_bad_div;
    bit o_timeout;

    // Tallies observed phases until DONE/ABORTED or the cycle budget runs out.
    task automatic observe(input int max_cyc, input int perturb_at, input int exp_div);
        o_stress = 0; o_settle = 0; o_meas = 0; o_gap = 0;
        o_load = 0; o_done = 0; o_ab = 0; o_bad_div = 0;
        o_timeout = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (i == perturb_at) begin
                bus.stress_cycles = 8'd20;
                bus.div_sel_cfg   = 2'b10;
                bus.start         = 1'b1;
            end else if (i == perturb_at + 1) begin
                bus.start = 1'b0;
            end
            case (int'(bus.phase))
                P_STRESS: o_stress++;
                P_SETTLE: o_settle++;
                P_MEAS:   o_meas++;
                P_GAP:    o_gap++;
                default:  ;
            endcase
            if (bus.load) o_load++;
            if (bus.load && (int'(bus.vco_div_sel) != exp_div)) o_bad_div++;
            if (bus.done) o_done++;
            if (bus.aborted) o_ab++;
            if (bus.done || bus.aborted) begin
                o_timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", bus.phase, 0);
        chk("rst_div",   bus.vco_div_sel, 3);
        chk("rst_rc",    bus.round_cnt, 0);
        chk("rst_busy",  bus.busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // two rounds, 10 stress / 5 measure
        set_cfg(10, 5, 2, 0);
        pulse_start();
        observe(200, -1, 0);
        chk("r1_timeout", o_timeout, 0);
        chk("r1_stress",  o_stress, 20);
        chk("r1_settle",  o_settle, 8);
        chk("r1_load",    o_load, 10);
        chk("r1_gap",     o_gap, 2);
        chk("r1_done",    o_done, 1);
        chk("r1_rc",      bus.round_cnt, 2);
        @(posedge clk); #1;
        chk("r1_done_pulse", bus.done, 0);

        // zero stress and zero measure
        set_cfg(0, 0, 1, 1);
        pulse_start();
        observe(50, -1, 1);
        chk("r2_stress", o_stress, 0);
        chk("r2_settle", o_settle, 4);
        chk("r2_load",   o_load, 1);
        chk("r2_done",   o_done, 1);
        chk("r2_rc",     bus.round_cnt, 1);
        @(posedge clk); #1;

        // abort in the third measure cycle of round 1
        set_cfg(3, 5, 2, 2);
        pulse_start();
        repeat (9) begin @(posedge clk); #1; end
        chk("r3_in_meas", bus.phase, 3);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("r3_phase",   bus.phase, 0);
        chk("r3_load",    bus.load, 0);
        chk("r3_aborted", bus.aborted, 1);
        chk("r3_done",    bus.done, 0);
        chk("r3_rc",      bus.round_cnt, 0);
        @(posedge clk); #1;
        chk("r3_ab_pulse", bus.aborted, 0);

        // config change and extra START mid-run
        set_cfg(6, 3, 2, 1);
        pulse_start();
        observe(200, 3, 1);
        chk("r4_stress",  o_stress, 12);
        chk("r4_settle",  o_settle, 8);
        chk("r4_meas",    o_meas, 6);
        chk("r4_bad_div", o_bad_div, 0);
        chk("r4_done",    o_done, 1);
        @(posedge clk); #1;

        // zero rounds, then START+ABORT in IDLE
        set_cfg(5, 5, 0, 0);
        pulse_start();
        chk("r5_done",  bus.done, 1);
        chk("r5_busy",  bus.busy, 0);
        @(posedge clk); #1;
        chk("r5_done2", bus.done, 0);
        chk("r5_busy2", bus.busy, 0);
        set_cfg(5, 5, 1, 0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("r5_sa_phase",   bus.phase, 0);
        chk("r5_sa_aborted", bus.aborted, 0);
        chk("r5_sa_done",    bus.done, 0);

        // reset during SETTLE
        set_cfg(2, 3, 3, 0);
        pulse_start();
        repeat (3) begin @(posedge clk); #1; end
        chk("r6_in_settle", bus.phase, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("r6_phase", bus.phase, 0);
        chk("r6_en",    bus.en_vco, 0);
        chk("r6_kill",  bus.clk_kill, 0);
        chk("r6_div",   bus.vco_div_sel, 3);
        chk("r6_rc",    bus.round_cnt, 0);
        chk("r6_done",  bus.done, 0);
        chk("r6_ab",    bus.aborted, 0);
        @(posedge clk); #1;
        chk("r6_done2", bus.done, 0);

        // all-ones stress length
        set_cfg(255, 1, 1, 3);
        pulse_start();
        observe(400, -1, 3);
        chk("r7_stress", o_stress, 255);
        chk("r7_load",   o_load, 1);
        chk("r7_done",   o_done, 1);
        @(posedge clk); #1;

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(0, 9) == 0);
            bus.abort = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0)
                set_cfg($urandom_range(0, 12), $urandom_range(0, 6),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
